// File: rtl/yags_pkg.sv
`default_nettype none
// ============================================================================
// Module  : yags_pkg
// Brief   : Shared YAGS types: 2-bit counter states, saturating update, FSM.
// Revision: 1.0 - initial release
// ============================================================================
package yags_pkg;

  typedef logic [1:0] counter_t;

  localparam counter_t strongly_not_taken_state = 2'd0;
  localparam counter_t weakly_not_taken_state   = 2'd1;
  localparam counter_t weakly_taken_state       = 2'd2;
  localparam counter_t strongly_taken_state     = 2'd3;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } pht_state_e;

  function automatic counter_t sat_update(input counter_t cnt, input logic taken);
    counter_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != strongly_taken_state) nxt = cnt + 2'd1;
    end else begin
      if (cnt != strongly_not_taken_state) nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/yags_choice_pht_if.sv
`default_nettype none
// ============================================================================
// Module  : yags_choice_pht_if
// Brief   : Fetch/EX signal bundle between the pipeline and the choice PHT.
// Revision: 1.0 - initial release
// ============================================================================
interface yags_choice_pht_if #(
  parameter int PC_size  = 10,
  parameter int GHR_size = 10
);
  logic [PC_size-1:0]  Current_PC;
  logic                branch;
  logic                final_prediction;
  logic [PC_size-1:0]  PC_from_branch_comp;
  logic                branch_signal;
  logic                actual_prediction;
  logic                PHT_prediction_EX;
  logic                final_prediction_EX;
  logic                cache_hit_EX;
  logic                cache_prediction_EX;
  logic [GHR_size-1:0] GHR_EX;
  logic                PHT_prediction;
  logic [GHR_size-1:0] GHR;
  logic                init_busy;

  modport master (
    output Current_PC, branch, final_prediction, PC_from_branch_comp,
           branch_signal, actual_prediction, PHT_prediction_EX,
           final_prediction_EX, cache_hit_EX, cache_prediction_EX, GHR_EX,
    input  PHT_prediction, GHR, init_busy
  );

  modport slave (
    input  Current_PC, branch, final_prediction, PC_from_branch_comp,
           branch_signal, actual_prediction, PHT_prediction_EX,
           final_prediction_EX, cache_hit_EX, cache_prediction_EX, GHR_EX,
    output PHT_prediction, GHR, init_busy
  );
endinterface
`default_nettype wire

// File: rtl/yags_choice_pht_ghr_reg.sv
`default_nettype none
// ============================================================================
// Module  : ghr_reg
// Brief   : Speculative global history; EX repair beats the Fetch shift.
// Revision: 1.0 - initial release
// ============================================================================
module ghr_reg #(
  parameter int GHR_size = 10
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                en,
  input  wire logic                mispredict,
  input  wire logic [GHR_size-1:0] ghr_ex,
  input  wire logic                actual,
  input  wire logic                fetch_valid,
  input  wire logic                fetch_bit,
  output logic      [GHR_size-1:0] ghr
);

  logic [GHR_size-1:0] ghr_q;
  logic [GHR_size-1:0] ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (en) begin
      if (mispredict) begin
        ghr_d = {ghr_ex[GHR_size-2:0], actual};
      end else if (fetch_valid) begin
        ghr_d = {ghr_q[GHR_size-2:0], fetch_bit};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign ghr = ghr_q;

endmodule
`default_nettype wire

// File: rtl/yags_choice_pht.sv
`default_nettype none
// ============================================================================
// Module  : yags_choice_pht
// Brief   : YAGS choice PHT (2-bit counters, init sweep) plus speculative GHR.
//           Optional macro CHOICE_PHT_GSHARE_EN xors history into the indices.
// Revision: 1.0 - initial release
// ============================================================================
module yags_choice_pht
  import yags_pkg::*;
#(
  parameter int PC_size  = 10,
  parameter int GHR_size = 10
) (
  input wire logic          clk,
  input wire logic          rst,
  yags_choice_pht_if.slave  bus
);

  localparam int ENTRIES = 2 ** PC_size;

  pht_state_e         state_q, state_d;
  logic [PC_size-1:0] sweep_q, sweep_d;
  counter_t           pht_q [ENTRIES];

  logic [PC_size-1:0] rd_idx;
  logic [PC_size-1:0] upd_idx;
  logic [PC_size-1:0] wr_idx;
  counter_t           wr_data;
  logic               wr_en;
  logic               ready;
  logic               upd_en;
  logic               mispredict;
  logic               cache_saved;
  logic [GHR_size-1:0] ghr_w;

  assign ready = (state_q == READY);

`ifdef CHOICE_PHT_GSHARE_EN
  logic [PC_size-1:0] ghr_ext;
  logic [PC_size-1:0] ghr_ex_ext;

  always_comb begin
    ghr_ext                   = '0;
    ghr_ex_ext                = '0;
    ghr_ext[GHR_size-1:0]     = ghr_w;
    ghr_ex_ext[GHR_size-1:0]  = bus.GHR_EX;
  end

  assign rd_idx  = bus.Current_PC ^ ghr_ext;
  assign upd_idx = bus.PC_from_branch_comp ^ ghr_ex_ext;
`else
  assign rd_idx  = bus.Current_PC;
  assign upd_idx = bus.PC_from_branch_comp;
`endif

  // The choice counter is left alone when it was wrong but the direction cache covered it.
  assign cache_saved = (bus.PHT_prediction_EX != bus.actual_prediction) && bus.cache_hit_EX &&
                       (bus.cache_prediction_EX == bus.actual_prediction);
  assign upd_en      = ready && bus.branch_signal && !cache_saved;
  assign mispredict  = bus.branch_signal && (bus.final_prediction_EX != bus.actual_prediction);

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    wr_en   = 1'b0;
    wr_idx  = upd_idx;
    wr_data = weakly_not_taken_state;
    case (state_q)
      INIT: begin
        wr_en   = 1'b1;
        wr_idx  = sweep_q;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = READY;
      end
      READY: begin
        if (upd_en) begin
          wr_en   = 1'b1;
          wr_data = sat_update(pht_q[upd_idx], bus.actual_prediction);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Table storage has no reset; the INIT sweep establishes its contents.
  always_ff @(posedge clk) begin
    if (wr_en) pht_q[wr_idx] <= wr_data;
  end

  ghr_reg #(
    .GHR_size (GHR_size)
  ) u_ghr_reg (
    .clk         (clk),
    .rst         (rst),
    .en          (ready),
    .mispredict  (mispredict),
    .ghr_ex      (bus.GHR_EX),
    .actual      (bus.actual_prediction),
    .fetch_valid (bus.branch),
    .fetch_bit   (bus.final_prediction),
    .ghr         (ghr_w)
  );

  assign bus.PHT_prediction = bus.branch && ready && pht_q[rd_idx][1];
  assign bus.GHR            = ghr_w;
  assign bus.init_busy      = !ready;

endmodule
`default_nettype wire

// File: doc/yags_choice_pht.md
# yags_choice_pht

Choice (bimodal) PHT and speculative global history register for the YAGS predictor. The block sits directly upstream of the not-taken and taken direction caches. In Fetch it supplies `PHT_prediction` and `GHR`; in EX it applies the YAGS choice-update rule and repairs the GHR after a mispredict.

## Interface
- `PC_size`, 10, PC bits used for indexing; the table has 2**PC_size entries
- `GHR_size`, 10, global history length; must be ≤ PC_size
- `clk`  input  1  clock; all state updates on the rising edge
- `rst`  input  1  asynchronous, active-high reset
- `Current_PC`  input  PC_size  Fetch-stage PC
- `branch`  input  1  Fetch instruction is a branch
- `final_prediction`  input  1  final YAGS direction chosen in Fetch (1 = taken)
- `PC_from_branch_comp`  input  PC_size  PC of the branch resolving in EX
- `branch_signal`  input  1  a branch resolves in EX this cycle
- `actual_prediction`  input  1  resolved outcome (1 = taken)
- `PHT_prediction_EX`  input  1  choice prediction, piped to EX
- `final_prediction_EX`  input  1  final prediction, piped to EX
- `cache_hit_EX`  input  1  the consulted direction cache hit
- `cache_prediction_EX`  input  1  that cache's prediction
- `GHR_EX`  input  GHR_size  GHR value sampled in Fetch, piped to EX
- `PHT_prediction`  output  1  choice direction (1 = taken)
- `GHR`  output  GHR_size  speculative history
- `init_busy`  output  1  table sweep in progress

## Operation
- Each entry is a 2-bit saturating counter: 0 strong-NT, 1 weak-NT, 2 weak-T, 3 strong-T. The prediction is bit 1.
- FSM states:
  - INIT: entered on reset. A sweep counter writes every entry to 1 (weak-NT), one entry per cycle, from index 0 upward.
  - After the entry at index 2**PC_size−1 is written, the FSM moves to READY.
- Read index is `Current_PC[PC_size-1:0]`. `PHT_prediction` = counter[index][1] when `branch` && READY, otherwise 0. The read is combinational.
- Update index is `PC_from_branch_comp`. An update occurs when READY && `branch_signal`, except when the choice was wrong but the cache was right, i.e. (`PHT_prediction_EX` != `actual_prediction`) && `cache_hit_EX` && (`cache_prediction_EX` == `actual_prediction`).
- On update, the counter increments if taken and decrements if not taken, saturating at 3 and 0.
- GHR rules, while READY:
  - Mispredict (`branch_signal` && `final_prediction_EX` != `actual_prediction`): GHR ← {GHR_EX[GHR_size-2:0], actual_prediction}.
  - Otherwise, if `branch`: GHR ← {GHR[GHR_size-2:0], final_prediction}.
  - Otherwise GHR holds.
- Mispredict repair takes priority over the Fetch shift in the same cycle; the Fetch shift is dropped.
- During INIT, all updates and GHR shifts are ignored.

## Timing
- Reset values: GHR = 0, `init_busy` = 1, `PHT_prediction` = 0, FSM in INIT, sweep counter = 0.
- `init_busy` stays 1 for exactly 2**PC_size cycles after `rst` falls, then drops to 0 in the cycle the FSM enters READY.
- Counter update and GHR update are visible on the cycle after the rising edge, giving 1-cycle latency.
- Read-during-write to the same entry returns the old counter value.
- Reset asserted mid-sweep or mid-operation restarts INIT from index 0 and clears the GHR.

## Configuration
- `CHOICE_PHT_GSHARE_EN`:
  - Defined: read index = `Current_PC` ^ zero-extended `GHR`; update index = `PC_from_branch_comp` ^ zero-extended `GHR_EX`.
  - Undefined: pure PC indexing as described above, and `GHR_EX` is used only for repair.

## Structure
- Shared package `yags_pkg`:
  - counter state localparams (strongly_not_taken_state … strongly_taken_state)
  - 2-bit counter typedef
  - `sat_update` function (counter, taken → next counter), reused by the direction caches
  - FSM state enum {INIT, READY}
- One sub-module, `ghr_reg`: the GHR with shift, repair, priority and reset.

## Test plan
- Reset, then release → `init_busy` = 1 for 1024 cycles, drops on cycle 1024; afterwards every read returns `PHT_prediction` = 0 (weak-NT).
- Resolve PC 0x05 taken twice (no cache hit) → counter 1→2→3; Fetch at 0x05 with `branch` = 1 gives `PHT_prediction` = 1. A third taken leaves it at 3.
- PC 0x05 at 3; resolve not-taken with `PHT_prediction_EX` = 1, `cache_hit_EX` = 1, `cache_prediction_EX` = 0 → no update, counter stays 3.
- GHR = 0x000; three Fetch branches predicted 1, 0, 1 → GHR = 0x005.
- Same cycle: Fetch branch predicted 1, plus EX mispredict with `GHR_EX` = 0x003, actual 0 → GHR = 0x006; the Fetch shift is discarded.
- Assert `rst` at sweep index 300 → `init_busy` remains 1 for a full 1024 cycles after release, and GHR = 0.
